// File: rtl/morse_pkg.sv
// Shared Morse timing constants: one-hot keyer states and element/gap lengths in time units.
// The receiver-side classifier thresholds use the same unit multipliers.
package morse_pkg;

  localparam logic [3:0] ST_IDLE     = 4'b0001;
  localparam logic [3:0] ST_MARK     = 4'b0010;
  localparam logic [3:0] ST_ELEM_GAP = 4'b0100;
  localparam logic [3:0] ST_CHAR_GAP = 4'b1000;

  localparam logic [2:0] DOT_U      = 3'd1;
  localparam logic [2:0] DASH_U     = 3'd3;
  localparam logic [2:0] ELEM_GAP_U = 3'd1;
  localparam logic [2:0] CHAR_GAP_U = 3'd3;
  localparam logic [2:0] WORD_GAP_U = 3'd7;

  localparam int unsigned MAX_LEN_DEFAULT = 6;

endpackage

// File: rtl/morse_keyer_if.sv
// Character handshake and key/sidetone outputs of the Morse keyer.
// master = pattern lookup side, slave = keyer.
interface morse_keyer_if
  import morse_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [2:0]         IN_LEN;
  logic [MAX_LEN-1:0] IN_PATTERN;
  logic               KEY;
  logic               BUSY;
  logic               DONE;
  logic               TONE;

  modport master (
    output IN_VALID, IN_LEN, IN_PATTERN,
    input  IN_READY, KEY, BUSY, DONE, TONE
  );

  modport slave (
    input  IN_VALID, IN_LEN, IN_PATTERN,
    output IN_READY, KEY, BUSY, DONE, TONE
  );
endinterface

// File: rtl/morse_unit_timer.sv
// Duration timer: on start, times units x UNIT_CYCLES clocks and flags expire in the last one.
// Counts up from 0 and clears itself on expiry, so it never wraps.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [2:0] units,
  output logic       expire
);
  localparam int unsigned CW = $clog2(32'(WORD_GAP_U) * UNIT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [2:0]    units_q;
  logic [31:0]   limit;

  assign limit  = 32'(units_q) * UNIT_CYCLES - 32'd1;
  assign expire = (units_q != 3'd0) && (32'(cnt_q) == limit);

  // start wins over expire so back-to-back intervals have no idle cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      units_q <= '0;
    end else if (start) begin
      cnt_q   <= '0;
      units_q <= units;
    end else if (expire) begin
      cnt_q   <= '0;
      units_q <= '0;
    end else if (units_q != 3'd0) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: sends one dot/dash pattern per accepted character on KEY with standard timing.
// Define MORSE_KEYER_SIDETONE_EN to build the TONE square-wave divider; otherwise TONE is 0.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6000000,
  parameter int unsigned MAX_LEN     = MAX_LEN_DEFAULT,
  parameter int unsigned TONE_HALF   = 50000
) (
  input logic           CLK,
  input logic           RESET,
  morse_keyer_if.slave  bus
);
  localparam int unsigned IW = $clog2(MAX_LEN + 1);

  if (UNIT_CYCLES < 2) begin : g_bad_unit
    $error("UNIT_CYCLES must be at least 2");
  end
  if (TONE_HALF < 1) begin : g_bad_tone
    $error("TONE_HALF must be at least 1");
  end

  logic [3:0]         state_q, state_d;
  logic [IW-1:0]      len_q, len_d, idx_q, idx_d, idx_inc, len_clamp;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic               key_q, key_d, ready_q, ready_d, busy_q, done_q, done_d;
  logic               t_start, t_expire;
  logic [2:0]         t_units;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .start (t_start),
    .units (t_units),
    .expire(t_expire)
  );

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    if (32'(bus.IN_LEN) > MAX_LEN) len_clamp = IW'(MAX_LEN);
    else                           len_clamp = IW'(bus.IN_LEN);
  end

  // pat_q shifts right at each mark end so bit 0 is always the next element
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    t_start = 1'b0;
    t_units = DOT_U;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.IN_VALID) begin
          len_d   = len_clamp;
          pat_d   = bus.IN_PATTERN;
          idx_d   = '0;
          t_start = 1'b1;
          if (len_clamp == '0) begin
            state_d = ST_CHAR_GAP;
            t_units = WORD_GAP_U;
          end else begin
            state_d = ST_MARK;
            t_units = bus.IN_PATTERN[0] ? DASH_U : DOT_U;
          end
        end
      end
      ST_MARK: begin
        if (t_expire) begin
          idx_d   = idx_inc;
          pat_d   = pat_q >> 1;
          t_start = 1'b1;
          if (idx_inc < len_q) begin
            state_d = ST_ELEM_GAP;
            t_units = ELEM_GAP_U;
          end else begin
            state_d = ST_CHAR_GAP;
            t_units = CHAR_GAP_U;
          end
        end
      end
      ST_ELEM_GAP: begin
        if (t_expire) begin
          state_d = ST_MARK;
          t_start = 1'b1;
          t_units = pat_q[0] ? DASH_U : DOT_U;
        end
      end
      ST_CHAR_GAP: begin
        if (t_expire) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_d   = (state_d == ST_MARK);
  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      ready_q <= ready_d;
      busy_q  <= ~ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.KEY      = key_q;
  assign bus.IN_READY = ready_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int unsigned TW = $clog2(TONE_HALF + 1);

  logic [TW-1:0] tone_cnt_q;
  logic          tone_q;

  // Cleared whenever KEY is (or is about to be) low, so each mark starts a fresh divider
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (!key_d || !key_q) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (32'(tone_cnt_q) == TONE_HALF - 1) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  assign bus.TONE = tone_q;
`else
  assign bus.TONE = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4, TONE_HALF=2, MAX_LEN=6.
module tb_morse_keyer;
  localparam int unsigned UNIT = 4;

  typedef struct {
    string      name;
    logic [2:0] len;
    logic [5:0] pat;
    int         exp_done;
    int         exp_high;
    int         exp_rises;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  morse_keyer_if #(.MAX_LEN(6)) bus ();

  morse_keyer #(
    .UNIT_CYCLES(UNIT),
    .MAX_LEN    (6),
    .TONE_HALF  (2)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Offers one character, then watches KEY/TONE/handshake each cycle until DONE.
  task automatic run_char(input logic [2:0] len, input logic [5:0] pat,
                          output int done_at, output int high, output int rises,
                          output int proto_err, output int tone_edges, output int tone_err,
                          output logic [127:0] keys);
    logic pk, pt, k;
    done_at = -1; high = 0; rises = 0; proto_err = 0; tone_edges = 0; tone_err = 0;
    keys = '0; pk = 1'b0; pt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 50 && !bus.IN_READY; i++) @(negedge clk);
    if (!bus.IN_READY) proto_err++;
    bus.IN_VALID = 1'b1; bus.IN_LEN = len; bus.IN_PATTERN = pat;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0; bus.IN_LEN = 3'd3; bus.IN_PATTERN = 6'b101011;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      k = bus.KEY;
      if (c < 128) keys[c] = k;
      if (k) high++;
      if (k && !pk) rises++;
      pk = k;
      if (bus.TONE !== pt) tone_edges++;
      pt = bus.TONE;
      if (!k && bus.TONE) tone_err++;
      if (bus.DONE) begin
        done_at = c;
        if (!bus.IN_READY || bus.BUSY || k) proto_err++;
        break;
      end
      if (bus.IN_READY || !bus.BUSY) proto_err++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int done_at, high, rises, perr, tedges, terr, tone_total, errs, stray;
    int d1, d2;
    logic r_at_done, k_at_done, k_next;
    logic [127:0] keys;
    logic exp_k;

    vecs[0] = '{"A",       3'd2, 6'b000010,  33, 16, 2};
    vecs[1] = '{"E",       3'd1, 6'b000000,  17,  4, 1};
    vecs[2] = '{"T",       3'd1, 6'b000001,  25, 12, 1};
    vecs[3] = '{"word",    3'd0, 6'b111111,  29,  0, 0};
    vecs[4] = '{"clamp7",  3'd7, 6'b111111, 105, 72, 6};
    vecs[5] = '{"K",       3'd3, 6'b000101,  49, 28, 3};
    vecs[6] = '{"N_upper", 3'd2, 6'b111101,  33, 16, 2};
    vecs[7] = '{"dots6",   3'd6, 6'b000000,  57, 24, 6};

    bus.IN_VALID = 1'b0; bus.IN_LEN = 3'd0; bus.IN_PATTERN = 6'd0;
    tone_total = 0;

    #12;
    check("reset_key",   int'(bus.KEY), 0);
    check("reset_done",  int'(bus.DONE), 0);
    check("reset_ready", int'(bus.IN_READY), 1);
    check("reset_busy",  int'(bus.BUSY), 0);
    check("reset_tone",  int'(bus.TONE), 0);
    @(negedge clk);
    rst = 1'b0;

    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.KEY || bus.DONE || !bus.IN_READY) errs++;
    end
    check("idle_no_valid", errs, 0);

    for (int v = 0; v < 8; v++) begin
      run_char(vecs[v].len, vecs[v].pat, done_at, high, rises, perr, tedges, terr, keys);
      check({vecs[v].name, "_done_cycle"}, done_at, vecs[v].exp_done);
      check({vecs[v].name, "_key_high"},   high,    vecs[v].exp_high);
      check({vecs[v].name, "_key_rises"},  rises,   vecs[v].exp_rises);
      check({vecs[v].name, "_handshake"},  perr,    0);
      tone_total += tedges;
      @(negedge clk);
      check({vecs[v].name, "_done_pulse"}, int'(bus.DONE), 0);
    end
`ifndef MORSE_KEYER_SIDETONE_EN
    check("tone_tied_low", tone_total, 0);
`endif

    // 'A' exact waveform: high 1-4, low 5-8, high 9-20, low 21-32
    run_char(3'd2, 6'b000010, done_at, high, rises, perr, tedges, terr, keys);
    errs = 0;
    for (int c = 1; c <= 32; c++) begin
      exp_k = (c <= 4) || (c >= 9 && c <= 20);
      if (keys[c] !== exp_k) errs++;
    end
    check("A_wave_mismatches", errs, 0);

    // Back-to-back 'E' with IN_VALID held high
    @(negedge clk);
    bus.IN_VALID = 1'b1; bus.IN_LEN = 3'd1; bus.IN_PATTERN = 6'd0;
    @(posedge clk);
    d1 = -1; d2 = -1; r_at_done = 1'b0; k_at_done = 1'b1; k_next = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (d1 < 0 && bus.DONE) begin
        d1 = c; r_at_done = bus.IN_READY; k_at_done = bus.KEY;
      end else if (d1 > 0 && c == d1 + 1) begin
        k_next = bus.KEY; bus.IN_VALID = 1'b0;
      end else if (d1 > 0 && bus.DONE) begin
        d2 = c;
        break;
      end
    end
    bus.IN_VALID = 1'b0;
    check("b2b_first_done",     d1, 17);
    check("b2b_ready_in_done",  int'(r_at_done), 1);
    check("b2b_key_in_done",    int'(k_at_done), 0);
    check("b2b_key_after_done", int'(k_next), 1);
    check("b2b_second_done",    d2, 34);

    // Reset during the dash of 'A'
    @(negedge clk);
    bus.IN_VALID = 1'b1; bus.IN_LEN = 3'd2; bus.IN_PATTERN = 6'b000010;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_key_before", int'(bus.KEY), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_key",   int'(bus.KEY), 0);
    check("abort_ready", int'(bus.IN_READY), 1);
    check("abort_done",  int'(bus.DONE), 0);
    check("abort_busy",  int'(bus.BUSY), 0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.DONE || bus.KEY || !bus.IN_READY) stray++;
    end
    check("abort_quiet", stray, 0);
    run_char(3'd2, 6'b000010, done_at, high, rises, perr, tedges, terr, keys);
    errs = 0;
    for (int c = 1; c <= 32; c++) begin
      exp_k = (c <= 4) || (c >= 9 && c <= 20);
      if (keys[c] !== exp_k) errs++;
    end
    check("after_abort_wave", errs, 0);
    check("after_abort_done", done_at, 33);

`ifdef MORSE_KEYER_SIDETONE_EN
    run_char(3'd1, 6'b000001, done_at, high, rises, perr, tedges, terr, keys);
    check("tone_edges",     tedges, 6);
    check("tone_while_off", terr, 0);
    @(negedge clk);
    check("tone_after",     int'(bus.TONE), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
